// File: rtl/set_bit_scheduler_pkg.sv
// Shared types and helpers for the set-bit scheduler.
// Optional out_last port is enabled by defining SET_BIT_SCHED_LAST_EN.
package set_bit_scheduler_pkg;

   localparam int INPUT_WIDTH_MAX = 64;

   typedef enum logic {IDLE, SCAN} state_t;

   function automatic int calc_idx_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/msb_index_comb.sv
// Combinational MSB search: index of the highest set bit, any-set flag,
// and a detect for "at most one bit set" (bitmap & (bitmap-1) == 0).
module msb_index_comb #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic [WIDTH-1:0] bitmap,
   output logic [IDX_W-1:0] index,
   output logic             any_set,
   output logic             at_most_one
);

   // NOTE: index gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (bitmap[i]) index = IDX_W'(i);
      end
   end

   assign any_set     = |bitmap;
   assign at_most_one = ((bitmap & (bitmap - WIDTH'(1))) == '0);

endmodule

// File: rtl/set_bit_scheduler.sv
// Accepts a bitmap and streams out the index of each set bit, highest first.
// Define SET_BIT_SCHED_LAST_EN to add out_last, flagging the final index of a word.
module set_bit_scheduler
   import set_bit_scheduler_pkg::*;
#(
   parameter  int INPUT_WIDTH = 8,
   localparam int IDX_W       = calc_idx_w(INPUT_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INPUT_WIDTH-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IDX_W-1:0]       out_index,
   output logic                   done,
   output logic                   busy
`ifdef SET_BIT_SCHED_LAST_EN
   ,
   output logic                   out_last
`endif
);

   state_t                 state;
   logic [INPUT_WIDTH-1:0] pending;
   logic [IDX_W-1:0]       msb_idx;
   logic                   any_set;
   logic                   last_bit;

   msb_index_comb #(
      .WIDTH (INPUT_WIDTH),
      .IDX_W (IDX_W)
   ) u_msb (
      .bitmap      (pending),
      .index       (msb_idx),
      .any_set     (any_set),
      .at_most_one (last_bit)
   );

   assign in_ready  = (state == IDLE) && !rst;
   assign busy      = (state == SCAN);
   assign out_valid = (state == SCAN) && any_set;
   assign out_index = out_valid ? msb_idx : '0;

`ifdef SET_BIT_SCHED_LAST_EN
   assign out_last  = out_valid && last_bit;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  pending <= in_data;
                  if (in_data != '0) state <= SCAN;
                  else               done  <= 1'b1;
               end
            end
            SCAN: begin
               if (out_ready && any_set) begin
                  pending <= pending & ~(INPUT_WIDTH'(1) << msb_idx);
                  // Emitting the only remaining bit drains the word.
                  if (last_bit) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_set_bit_scheduler.sv
// Directed self-checking bench for set_bit_scheduler (8-bit and 5-bit instances).
// Define SET_BIT_SCHED_LAST_EN to also check out_last.
module tb_set_bit_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, out_ready;
   logic [7:0] in_data;
   logic       in_ready, out_valid, done, busy;
   logic [2:0] out_index;
   logic       in_valid5, out_ready5;
   logic [4:0] in_data5;
   logic       in_ready5, out_valid5, done5, busy5;
   logic [2:0] out_index5;
`ifdef SET_BIT_SCHED_LAST_EN
   logic       out_last, out_last5;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   set_bit_scheduler #(.INPUT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
      .done(done), .busy(busy)
`ifdef SET_BIT_SCHED_LAST_EN
      , .out_last(out_last)
`endif
   );

   set_bit_scheduler #(.INPUT_WIDTH(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_index(out_index5),
      .done(done5), .busy(busy5)
`ifdef SET_BIT_SCHED_LAST_EN
      , .out_last(out_last5)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present a word for one accept edge, then withdraw it.
   task automatic send(input logic [7:0] w);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      in_valid5 = 1'b0; in_data5 = '0; out_ready5 = 1'b0;
      tick(); tick();
      checks++;
      if ({in_ready, out_valid, busy, done, out_index} !== 7'b0) begin
         errors++;
         $display("FAIL reset_state got %b want 0000000", {in_ready, out_valid, busy, done, out_index});
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_basic_stream;
      int exp_idx [6] = '{7, 6, 4, 3, 2, 1};
      out_ready = 1'b1;
      send(8'hDE);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({out_valid, busy, done, out_index} !== {3'b110, 3'(exp_idx[i])}) begin
            errors++;
            $display("FAIL de_seq[%0d] got v/b/d/idx=%b want %b", i,
                     {out_valid, busy, done, out_index}, {3'b110, 3'(exp_idx[i])});
         end
         tick();
      end
      checks++;
      if ({done, in_ready, out_valid, busy} !== 4'b1100) begin
         errors++;
         $display("FAIL de_done got d/r/v/b=%b want 1100", {done, in_ready, out_valid, busy});
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL de_done_pulse got %b want 0", done);
      end
   endtask

   task automatic test_backpressure;
      int exp_idx [5] = '{7, 5, 3, 2, 0};
      int dones = 0;
      out_ready = 1'b1;
      send(8'hAD);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            out_ready = 1'b0;
            repeat (3) begin
               checks++;
               if ({out_valid, out_index} !== 4'b1101) begin
                  errors++;
                  $display("FAIL ad_stall got v/idx=%b want 1101", {out_valid, out_index});
               end
               dones += int'(done);
               tick();
            end
            out_ready = 1'b1;
         end
         checks++;
         if ({out_valid, out_index} !== {1'b1, 3'(exp_idx[i])}) begin
            errors++;
            $display("FAIL ad_seq[%0d] got v/idx=%b want %b", i, {out_valid, out_index},
                     {1'b1, 3'(exp_idx[i])});
         end
         dones += int'(done);
         tick();
      end
      dones += int'(done);
      tick();
      dones += int'(done);
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL ad_done_count got %0d want 1", dones);
      end
   endtask

   task automatic test_zero_word;
      out_ready = 1'b1;
      send(8'h00);
      checks++;
      if ({done, out_valid, busy, in_ready} !== 4'b1001) begin
         errors++;
         $display("FAIL zero_done got d/v/b/r=%b want 1001", {done, out_valid, busy, in_ready});
      end
      send(8'h01);
      checks++;
      if ({out_valid, done, out_index} !== 5'b10000) begin
         errors++;
         $display("FAIL zero_next_word got v/d/idx=%b want 10000", {out_valid, done, out_index});
      end
      tick();
      checks++;
      if ({done, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL zero_next_done got d/v=%b want 10", {done, out_valid});
      end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h80;
      tick();
      in_data   = 8'hFF;
      checks++;
      if ({out_valid, in_ready, out_index} !== 5'b10111) begin
         errors++;
         $display("FAIL b2b_80 got v/r/idx=%b want 10111", {out_valid, in_ready, out_index});
      end
`ifdef SET_BIT_SCHED_LAST_EN
      checks++;
      if (out_last !== 1'b1) begin
         errors++;
         $display("FAIL b2b_80_last got %b want 1", out_last);
      end
`endif
      tick();
      checks++;
      if ({done, in_ready, out_valid} !== 3'b110) begin
         errors++;
         $display("FAIL b2b_80_done got d/r/v=%b want 110", {done, in_ready, out_valid});
      end
      tick();
      for (int i = 7; i >= 0; i--) begin
         checks++;
         if ({out_valid, in_ready, done, out_index} !== {3'b100, 3'(i)}) begin
            errors++;
            $display("FAIL b2b_ff[%0d] got v/r/d/idx=%b want %b", i,
                     {out_valid, in_ready, done, out_index}, {3'b100, 3'(i)});
         end
`ifdef SET_BIT_SCHED_LAST_EN
         checks++;
         if (out_last !== (i == 0)) begin
            errors++;
            $display("FAIL b2b_ff_last[%0d] got %b want %b", i, out_last, (i == 0));
         end
`endif
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if ({done, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL b2b_ff_done got d/v/b=%b want 100", {done, out_valid, busy});
      end
      tick();
   endtask

   task automatic test_reset_mid_scan;
      int exp_idx [4] = '{7, 6, 3, 1};
      out_ready = 1'b1;
      send(8'hBE);
      checks++;
      if ({out_valid, out_index} !== 4'b1111) begin
         errors++;
         $display("FAIL rst_mid_7 got v/idx=%b want 1111", {out_valid, out_index});
      end
      tick();
      checks++;
      if ({out_valid, out_index} !== 4'b1101) begin
         errors++;
         $display("FAIL rst_mid_5 got v/idx=%b want 1101", {out_valid, out_index});
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({out_valid, busy, done, in_ready, out_index} !== 7'b0) begin
         errors++;
         $display("FAIL rst_mid_outputs got %b want 0000000", {out_valid, busy, done, in_ready, out_index});
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_in_ready got %b want 1", in_ready);
      end
      send(8'hCA);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({out_valid, out_index} !== {1'b1, 3'(exp_idx[i])}) begin
            errors++;
            $display("FAIL ca_seq[%0d] got v/idx=%b want %b", i, {out_valid, out_index},
                     {1'b1, 3'(exp_idx[i])});
         end
         tick();
      end
      checks++;
      if ({done, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL ca_done got d/v=%b want 10", {done, out_valid});
      end
      tick();
   endtask

   task automatic test_width5;
      int exp_idx [3] = '{4, 1, 0};
      out_ready5 = 1'b1;
      in_valid5  = 1'b1;
      in_data5   = 5'b10011;
      tick();
      in_valid5  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({out_valid5, done5, out_index5} !== {2'b10, 3'(exp_idx[i])}) begin
            errors++;
            $display("FAIL w5_seq[%0d] got v/d/idx=%b want %b", i, {out_valid5, done5, out_index5},
                     {2'b10, 3'(exp_idx[i])});
         end
`ifdef SET_BIT_SCHED_LAST_EN
         checks++;
         if (out_last5 !== (i == 2)) begin
            errors++;
            $display("FAIL w5_last[%0d] got %b want %b", i, out_last5, (i == 2));
         end
`endif
         tick();
      end
      checks++;
      if ({done5, out_valid5, in_ready5} !== 3'b101) begin
         errors++;
         $display("FAIL w5_done got d/v/r=%b want 101", {done5, out_valid5, in_ready5});
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_stream();
      test_backpressure();
      test_zero_word();
      test_back_to_back();
      test_reset_mid_scan();
      test_width5();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/set_bit_scheduler.md
Name: set_bit_scheduler

Overview:
Sequencer wrapped around the MSB-search datapath. Accepts one INPUT_WIDTH-bit word over a valid/ready handshake, then emits the index of every set bit, highest first, one per output handshake, clearing each bit as it is emitted. Used to turn request/flag bitmaps into an ordered stream of work items for downstream units.

Parameters:
INPUT_WIDTH, 8, width of the input bitmap; legal range is 2..64.
IDX_W, $clog2(INPUT_WIDTH), derived localparam: width of the index output.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input word present.
in_ready  out  1  block can accept a word.
in_data  in  INPUT_WIDTH  bitmap to schedule.
out_valid  out  1  out_index is valid.
out_ready  in  1  consumer takes out_index.
out_index  out  IDX_W  index of the highest remaining set bit.
done  out  1  one-cycle pulse when the current word is fully drained.
busy  out  1  high while a word is held (state SCAN).

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. All state is sampled on the rising edge of clk.
- Reset: state=IDLE, pending=0, done=0, out_valid=0, out_index=0, busy=0. in_ready=0 during any cycle with rst=1, and 1 from the first cycle after reset is released.
- States: IDLE and SCAN. in_ready = (state==IDLE) && !rst. Words are not overlapped; a new word is never accepted while in SCAN.
- IDLE, accept (in_valid && in_ready):
  - pending <= in_data.
  - If in_data != 0, go to SCAN.
  - If in_data == 0, stay in IDLE; done=1 in the next cycle and no outputs are emitted.
- SCAN:
  - out_valid=1 and busy=1.
  - out_index = position of the highest 1 in pending, decoded combinationally from the pending register.
  - Latency: first out_valid appears in the cycle after the accept.
- Output handshake (out_valid && out_ready): clear bit out_index of pending.
  - If the cleared pending would be 0, go to IDLE and pulse done=1 in the next cycle, which is also the cycle in_ready rises.
  - Otherwise stay in SCAN; the next index appears in the next cycle.
- Backpressure: while out_valid && !out_ready, out_index and pending hold stable.
- Throughput: a word with k set bits takes k cycles in SCAN plus 1 accept cycle, when out_ready is held at 1.
- When out_valid=0, out_index is driven to 0.
- Reset mid-SCAN: the word is discarded, no done pulse, and all outputs take their reset values in the next cycle.
- rst has priority over any handshake in the same cycle.

Optional Feature:
Macro SET_BIT_SCHED_LAST_EN.
- Defined: adds output port out_last (1 bit), asserted together with out_valid when pending has exactly one set bit, i.e. on the final index of a word. out_last is 0 at reset and whenever out_valid=0.
- Not defined: the port is absent. The downstream consumer relies on done instead.

Decomposition:
- Package set_bit_scheduler_pkg:
  - state enum {IDLE, SCAN};
  - function computing IDX_W from the width;
  - constant INPUT_WIDTH_MAX=64.
- Sub-module msb_index_comb: purely combinational. Input is a bitmap, outputs are index and any_set. It is instantiated on pending. It also provides the "one bit left" detect, pending & (pending-1) == 0, used for out_last and for the drain check.

Test Plan:
- Accept 0xDE with out_ready=1 → out_index sequence 7,6,4,3,2,1 on consecutive cycles; done pulses the cycle after index 1; in_ready=1 on that same cycle.
- Accept 0xAD, drop out_ready for 3 cycles while index 5 is shown → out_index holds 5 with out_valid=1 throughout; the full sequence is 7,5,3,2,0; exactly one done pulse.
- Accept 0x00 → no out_valid; done=1 exactly one cycle after the accept; stays in IDLE; the next word is accepted on the following cycle.
- Accept 0x80, then 0xFF back-to-back → index 7 then done; then 7,6,5,4,3,2,1,0. in_ready=0 throughout SCAN, so in_valid held high during SCAN is not taken. With SET_BIT_SCHED_LAST_EN, out_last=1 only on each index 7 of 0x80 and on index 0 of 0xFF.
- Accept 0xBE, assert rst after indices 7,5 → next cycle out_valid=0, busy=0, done=0. in_ready=1 after rst is released; re-sending 0xCA yields 7,6,3,1.
- INPUT_WIDTH=5, accept 5'b10011 → out_index (3 bits) sequence 4,1,0, then done.
